// File: rtl/traffic_light_pkg.sv
// Shared encodings for the active-low traffic-light bus and its decoded phase.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package traffic_light_pkg;

   // Active-low lamp patterns as driven on the bus
   localparam logic [2:0] LIGHT_RED   = 3'b011;
   localparam logic [2:0] LIGHT_BLUE  = 3'b101;
   localparam logic [2:0] LIGHT_GREEN = 3'b110;
   localparam logic [2:0] LIGHT_OFF   = 3'b111;

   // Decoded phase codes
   localparam logic [1:0] PH_OFF   = 2'd0;
   localparam logic [1:0] PH_RED   = 2'd1;
   localparam logic [1:0] PH_BLUE  = 2'd2;
   localparam logic [1:0] PH_GREEN = 2'd3;

   // Bit positions inside the sticky error vector
   localparam int ERR_PAT   = 0;
   localparam int ERR_TRANS = 1;
   localparam int ERR_TMO   = 2;

   // True when 'to' may directly follow lit phase 'from'
   function automatic logic legal_succ(input logic [1:0] from,
                                       input logic [1:0] to,
                                       input logic       blue_opt);
      logic ok;
      ok = 1'b0;
      case (from)
         PH_GREEN: ok = (to == PH_RED);
         PH_RED:   ok = (to == PH_BLUE) || (blue_opt && (to == PH_GREEN));
         PH_BLUE:  ok = (to == PH_GREEN);
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/traffic_phase_decode.sv
// Combinational decode of the active-low lights bus into a phase code.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; unrecognised patterns decode as OFF with illegal set.
module traffic_phase_decode
   import traffic_light_pkg::*;
(
   input  logic [2:0] lights,
   output logic [1:0] phase,
   output logic       illegal
);

   // Map each legal pattern to its phase; everything else is OFF + illegal
   always_comb begin
      phase   = PH_OFF;
      illegal = 1'b0;
      case (lights)
         LIGHT_RED:   phase = PH_RED;
         LIGHT_BLUE:  phase = PH_BLUE;
         LIGHT_GREEN: phase = PH_GREEN;
         LIGHT_OFF:   phase = PH_OFF;
         default:     illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker: decodes lights, times each phase, flags sequence errors, counts cycles.
// Latency: 1 cycle from lights to phase/phase_chg/dwell/last_dwell/err/cycle_cnt.
// Backpressure: none; observe-only, never stalls the bus.
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int MAX_DWELL = 16,
   parameter int BLUE_OPT  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       lights,
   input  logic             clr,
   output logic [1:0]       phase,
   output logic             phase_chg,
   output logic [CNT_W-1:0] dwell,
   output logic [CNT_W-1:0] last_dwell,
   output logic [2:0]       err,
   output logic             err_any,
   output logic [7:0]       cycle_cnt
);

   localparam logic [CNT_W-1:0] DWELL_SAT = '1;
   localparam logic [CNT_W-1:0] DWELL_TMO = CNT_W'(MAX_DWELL);
   localparam logic             SKIP_BLUE = (BLUE_OPT != 0);

   logic [1:0]       phase_nxt;
   logic             illegal;
   logic             chg;
   logic [CNT_W-1:0] dwell_nxt;
   logic             lit_entry;
   logic             entry_ok;
   logic             tmo_hit;
   logic             cyc_inc;
   logic [2:0]       err_set;
   logic [1:0]       last_lit;
   logic             last_lit_vld;

   traffic_phase_decode u_decode (
      .lights  (lights),
      .phase   (phase_nxt),
      .illegal (illegal)
   );

   // Change detection, dwell update, entry legality, timeout and cycle-count qualifiers
   always_comb begin
      chg       = (phase_nxt != phase);
      dwell_nxt = dwell;
      entry_ok  = 1'b1;
      tmo_hit   = 1'b0;
      cyc_inc   = 1'b0;
      err_set   = 3'b000;

      if (chg)
         dwell_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (dwell != DWELL_SAT)
         dwell_nxt = dwell + 1'b1;

      lit_entry = chg && (phase_nxt != PH_OFF);

      // OFF gaps are transparent: compare against the last lit phase, not 'phase'
      if (last_lit_vld && (phase_nxt != last_lit))
         entry_ok = legal_succ(last_lit, phase_nxt, SKIP_BLUE);

      // Fire only on the edge where dwell arrives at the threshold, not while parked at saturation
      tmo_hit = (phase_nxt != PH_OFF) && (dwell_nxt == DWELL_TMO) && (chg || (dwell != DWELL_TMO));

      cyc_inc = lit_entry && (phase_nxt == PH_GREEN) && last_lit_vld && (last_lit != PH_GREEN);

      err_set[ERR_PAT]   = illegal;
      err_set[ERR_TRANS] = lit_entry && !entry_ok;
      err_set[ERR_TMO]   = tmo_hit;
   end

   // Phase, change pulse and dwell timers: unaffected by clr
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= PH_OFF;
         phase_chg <= 1'b0;
         dwell     <= '0;
      end else begin
         phase     <= phase_nxt;
         phase_chg <= chg;
         dwell     <= dwell_nxt;
      end
   end

   // History and statistics: clr wipes them, then a same-cycle lit entry reloads last_lit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_dwell   <= '0;
         last_lit     <= PH_OFF;
         last_lit_vld <= 1'b0;
         cycle_cnt    <= '0;
      end else begin
         if (clr)
            last_dwell <= '0;
         else if (chg)
            last_dwell <= dwell;

         if (lit_entry) begin
            last_lit     <= phase_nxt;
            last_lit_vld <= 1'b1;
         end else if (clr) begin
            last_lit_vld <= 1'b0;
         end

         if (clr)
            cycle_cnt <= '0;
         else if (cyc_inc)
            cycle_cnt <= cycle_cnt + 8'd1;
      end
   end

   // Sticky error flags; errors coinciding with clr are discarded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 3'b000;
      else if (clr)
         err <= 3'b000;
      else
         err <= err | err_set;
   end

   assign err_any = |err;

endmodule
